// File: rtl/garo_entropy_ctrl.sv
// Gated ring-oscillator entropy controller: warm-up, divided sampling,
// repetition health test and word packing. Optional: GARO_VON_NEUMANN_EN.
module garo_entropy_ctrl #(
    parameter int WORD_W     = 8,
    parameter int WARMUP_CYC = 64,
    parameter int SAMPLE_DIV = 4,
    parameter int REP_LIMIT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              osc_bit,
    output logic              osc_run,
    output logic [WORD_W-1:0] data,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              health_fail,
    output logic              busy
);

    localparam int WC_W  = $clog2(WARMUP_CYC + 1);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BC_W  = $clog2(WORD_W + 1);
    localparam int RUN_W = $clog2(REP_LIMIT + 1);

    localparam logic [WC_W-1:0]  WARM_LAST = WC_W'(WARMUP_CYC - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [BC_W-1:0]  BIT_LAST  = BC_W'(WORD_W - 1);
    localparam logic [RUN_W-1:0] RUN_END   = RUN_W'(REP_LIMIT);

    typedef enum logic [1:0] {IDLE, WARMUP, COLLECT, OUTPUT} state_t;

    state_t             state_q, state_d;
    logic [WC_W-1:0]    wcnt_q, wcnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BC_W-1:0]    bcnt_q, bcnt_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               prev_q, prev_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic [WORD_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               hf_q, hf_d;
`ifdef GARO_VON_NEUMANN_EN
    logic               pend_q, pend_d;
    logic               first_q, first_d;
`endif

    logic               sample;
    logic               acc;
    logic               acc_bit;
    logic               fault;
    logic               word_done;
    logic [RUN_W-1:0]   run_nx;
    logic [WORD_W-1:0]  shreg_nx;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        div_d     = div_q;
        bcnt_d    = bcnt_q;
        run_d     = run_q;
        prev_d    = prev_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = valid_q;
        hf_d      = hf_q;
`ifdef GARO_VON_NEUMANN_EN
        pend_d    = pend_q;
        first_d   = first_q;
`endif
        sample    = 1'b0;
        acc       = 1'b0;
        acc_bit   = osc_bit;
        fault     = 1'b0;
        word_done = 1'b0;
        run_nx    = run_q;
        shreg_nx  = shreg_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = WARMUP;
                    wcnt_d  = '0;
                    run_d   = '0;
                end
            end
            WARMUP: begin
                wcnt_d = wcnt_q + 1'b1;
                if (!req) begin
                    state_d = IDLE;
                end else if (wcnt_q == WARM_LAST) begin
                    state_d = COLLECT;
                    div_d   = '0;
                    bcnt_d  = '0;
                    run_d   = '0;
                    shreg_d = '0;
`ifdef GARO_VON_NEUMANN_EN
                    pend_d  = 1'b0;
`endif
                end
            end
            COLLECT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sample = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
                if (sample) begin
                    // Run length is tracked on raw samples, before any debiasing
                    if (run_q != '0 && osc_bit == prev_q) begin
                        run_nx = run_q + 1'b1;
                    end else begin
                        run_nx = RUN_W'(1);
                    end
                    run_d  = run_nx;
                    prev_d = osc_bit;
                    fault  = (run_nx == RUN_END);
`ifdef GARO_VON_NEUMANN_EN
                    if (!pend_q) begin
                        pend_d  = 1'b1;
                        first_d = osc_bit;
                    end else begin
                        pend_d = 1'b0;
                        if (first_q != osc_bit) begin
                            acc     = 1'b1;
                            acc_bit = first_q;
                        end
                    end
`else
                    acc = 1'b1;
`endif
                end
                if (acc) begin
                    shreg_nx  = {shreg_q[WORD_W-2:0], acc_bit};
                    shreg_d   = shreg_nx;
                    bcnt_d    = bcnt_q + 1'b1;
                    word_done = (bcnt_q == BIT_LAST);
                end
                if (fault) begin
                    hf_d = 1'b1;
                end
                if (!req) begin
                    state_d = IDLE;
                end else if (fault) begin
                    state_d = WARMUP;
                    wcnt_d  = '0;
                    run_d   = '0;
                end else if (word_done) begin
                    state_d = OUTPUT;
                    data_d  = shreg_nx;
                    valid_d = 1'b1;
                end
            end
            OUTPUT: begin
                if (data_ready) begin
                    valid_d = 1'b0;
                    if (req) begin
                        state_d = COLLECT;
                        div_d   = '0;
                        bcnt_d  = '0;
`ifdef GARO_VON_NEUMANN_EN
                        pend_d  = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            div_q   <= '0;
            bcnt_q  <= '0;
            run_q   <= '0;
            prev_q  <= 1'b0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            hf_q    <= 1'b0;
`ifdef GARO_VON_NEUMANN_EN
            pend_q  <= 1'b0;
            first_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            div_q   <= div_d;
            bcnt_q  <= bcnt_d;
            run_q   <= run_d;
            prev_q  <= prev_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            hf_q    <= hf_d;
`ifdef GARO_VON_NEUMANN_EN
            pend_q  <= pend_d;
            first_q <= first_d;
`endif
        end
    end

    assign osc_run     = (state_q != IDLE);
    assign busy        = (state_q != IDLE);
    assign data        = data_q;
    assign data_valid  = valid_q;
    assign health_fail = hf_q;

endmodule
